// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the fetch/data memory bus arbiter.
// Optional watchdog abort is enabled by defining BUS_TIMEOUT_EN.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_ACC  = 2'd1,
        ARB_MEM_ACC = 2'd2
    } arb_state_t;

    localparam int STALL_IF_ID   = 1;
    localparam int STALL_MEM_WB  = 4;
    localparam int TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Access watchdog: counts busy cycles and strobes on the last allowed one.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    import mem_bus_arbiter_pkg::*;

    localparam logic [TIMEOUT_CNT_W-1:0] LIMIT =
        TIMEOUT_CNT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_CNT_W-1:0] cnt;

    // Cycle counter, restarted whenever the arbiter is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data port.
// Define BUS_TIMEOUT_EN to abort accesses that see no ack in TIMEOUT_CYC.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              stallreq_if_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stallreq_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_err_o
);
    import mem_bus_arbiter_pkg::*;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       if_done;
    logic       mem_done;
    logic       issue_if;
    logic       issue_mem;
    logic       if_fin;
    logic       mem_fin;
    logic       abort;
    logic       expire;
    logic       unused_stall;

    assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ARB_IDLE),
        .en     (state != ARB_IDLE),
        .expire (expire)
    );

    // One-cycle error pulse after an aborted access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= abort;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign expire         = 1'b0;
    assign bus_err_o      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; data port wins because it is the older instruction.
    always_comb begin
        state_nxt = state;
        issue_if  = 1'b0;
        issue_mem = 1'b0;
        if_fin    = 1'b0;
        mem_fin   = 1'b0;
        abort     = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (mem_ce_i && !mem_done) begin
                    state_nxt = ARB_MEM_ACC;
                    issue_mem = 1'b1;
                end else if (if_ce_i && !if_done) begin
                    state_nxt = ARB_IF_ACC;
                    issue_if  = 1'b1;
                end
            end
            ARB_IF_ACC: begin
                if (bus_ack_i || expire) begin
                    state_nxt = ARB_IDLE;
                    if_fin    = 1'b1;
                    abort     = !bus_ack_i;
                end
            end
            ARB_MEM_ACC: begin
                if (bus_ack_i || expire) begin
                    state_nxt = ARB_IDLE;
                    mem_fin   = 1'b1;
                    abort     = !bus_ack_i;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Bus launch registers, result registers and sticky done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
        end else begin
            if (issue_mem) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_we_i;
                bus_sel_o   <= mem_sel_i;
                bus_addr_o  <= mem_addr_i;
                bus_wdata_o <= mem_wdata_i;
            end else if (issue_if) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= 4'b1111;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= '0;
            end else if (if_fin || mem_fin) begin
                bus_req_o   <= 1'b0;
            end
            if (if_fin) begin
                if_data_o <= abort ? '0 : bus_rdata_i;
            end
            if (mem_fin) begin
                mem_rdata_o <= (abort || bus_we_o) ? '0 : bus_rdata_i;
            end
            if (!stall_i[STALL_IF_ID]) begin
                if_done <= 1'b0;
            end else if (if_fin) begin
                if_done <= 1'b1;
            end
            if (!stall_i[STALL_MEM_WB]) begin
                mem_done <= 1'b0;
            end else if (mem_fin) begin
                mem_done <= 1'b1;
            end
        end
    end

    assign stallreq_if_o  = if_ce_i && !if_done;
    assign stallreq_mem_o = mem_ce_i && !mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a bus responder and latency model.
// Runs the timeout scenario when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        stallreq_if;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        hold_if = 1'b0;

    int checks = 0;
    int errors = 0;

    bit          resp_en = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    int          lat_q[$];
    txn_t        log_q[$];
    int          gap_viol = 0;
    int          hold_viol = 0;
    int          err_total = 0;
    logic [31:0] bmem [logic [31:0]];

    int          if_rel;
    int          mem_rel;
    logic [31:0] if_got;
    logic [31:0] mem_got;
    int          rises[$];
    int          errs[$];
    bit          timed_out;

    always #5 clk = ~clk;

    // ctrl model: data stall freezes through mem_wb, fetch stall through if_id
    assign stall_i = (stallreq_mem ? 6'b011111 :
                      stallreq_if  ? 6'b000011 : 6'b000000) |
                     {4'b0000, hold_if, 1'b0};

    mem_bus_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .if_ce_i        (if_ce),
        .if_addr_i      (if_addr),
        .if_data_o      (if_data),
        .stallreq_if_o  (stallreq_if),
        .mem_ce_i       (mem_ce),
        .mem_we_i       (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_rdata_o    (mem_rdata),
        .stallreq_mem_o (stallreq_mem),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_sel_o      (bus_sel),
        .bus_addr_o     (bus_addr),
        .bus_wdata_o    (bus_wdata),
        .bus_ack_i      (bus_ack),
        .bus_rdata_i    (bus_rdata),
        .bus_err_o      (bus_err)
    );

    always @(posedge clk) begin
        if (bus_err) err_total <= err_total + 1;
    end

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Variable-latency memory: latency per access taken from lat_q.
    initial begin : responder
        int   left;
        bit   busy;
        int   c;
        int   last_ack;
        txn_t cur;
        left = 0;
        busy = 1'b0;
        c = 0;
        last_ack = -10;
        cur = '0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            bus_ack = force_ack;
            bus_rdata = force_rdata;
            if (!rst || !resp_en) begin
                busy = 1'b0;
                continue;
            end
            if (busy && {bus_we, bus_sel, bus_addr, bus_wdata} != cur)
                hold_viol++;
            if (bus_req && !busy) begin
                if (last_ack == c - 1) gap_viol++;
                busy = 1'b1;
                left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                cur = {bus_we, bus_sel, bus_addr, bus_wdata};
                log_q.push_back(cur);
            end
            if (busy) begin
                if (left == 0) begin
                    bus_ack = 1'b1;
                    busy = 1'b0;
                    last_ack = c;
                    if (cur.we) begin
                        bus_rdata = 32'hFFFF_FFFF;
                        bmem[cur.addr] = (mread(cur.addr) & ~bmask(cur.sel)) |
                                         (cur.wdata & bmask(cur.sel));
                    end else begin
                        bus_rdata = mread(cur.addr);
                    end
                end else begin
                    left--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pipeline model: a requester retires (ce dropped) once its stall releases.
    task automatic observe(input int bound);
        bit prev;
        prev = bus_req;
        if_rel = -1;
        mem_rel = -1;
        rises.delete();
        errs.delete();
        timed_out = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (c > 0) tick();
            #1;
            if (bus_req && !prev) rises.push_back(c);
            if (bus_err) errs.push_back(c);
            prev = bus_req;
            if (mem_ce && !stallreq_mem && mem_rel < 0) begin
                mem_rel = c;
                mem_got = mem_rdata;
                mem_ce = 1'b0;
            end
            if (if_ce && !stallreq_if && if_rel < 0) begin
                if_rel = c;
                if_got = if_data;
                if_ce = 1'b0;
            end
            if (!if_ce && !mem_ce && !bus_req) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_ce = 1'b0;
        if_addr = 32'h0;
        mem_ce = 1'b0;
        mem_we = 1'b0;
        mem_sel = 4'h0;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;
        resp_en = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus got req=%b we=%b sel=%h addr=%h wd=%h want all 0",
                     bus_req, bus_we, bus_sel, bus_addr, bus_wdata);
        end
        checks++;
        if (if_data !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got if=%h mem=%h want 0", if_data, mem_rdata);
        end
        checks++;
        if ({bus_err, stallreq_if, stallreq_mem} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000",
                     {bus_err, stallreq_if, stallreq_mem});
        end
        tick();
        rst = 1'b1;
        tick();
        if_ce = 1'b1;
        if_addr = 32'h40;
        tick();
        #1;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_up got %b want 1", bus_req);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_drop got %b want 0", bus_req);
        end
        if_ce = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        force_ack = 1'b1;
        force_rdata = 32'hBADC_0DE5;
        tick();
        #1;
        force_ack = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (if_data !== 32'h0 || mem_rdata !== 32'h0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_ignored got if=%h mem=%h req=%b want 0 0 0",
                     if_data, mem_rdata, bus_req);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_fetch_only();
        logic [31:0] a;
        logic [31:0] e;
        int k;
        bmem[32'h100] = 32'h3C01_1234;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 32'h100 :
                32'h1000_0000 | ($urandom_range(0, 1023) << 2);
            k = (i == 0) ? 3 : $urandom_range(0, 5);
            e = mread(a);
            lat_q.push_back(k);
            log_q.delete();
            tick();
            if_ce = 1'b1;
            if_addr = a;
            observe(40);
            checks++;
            if (timed_out || if_rel != k + 2) begin
                errors++;
                $display("FAIL fetch_stall_len got %0d want %0d", if_rel, k + 2);
            end
            checks++;
            if (if_got !== e) begin
                errors++;
                $display("FAIL fetch_data got %h want %h", if_got, e);
            end
            checks++;
            if (log_q.size() != 1 || log_q[0].addr !== a || log_q[0].we !== 1'b0 ||
                rises.size() != 1 || rises[0] != 1) begin
                errors++;
                $display("FAIL fetch_bus got n=%0d addr=%h rise=%0d want 1 %h 1",
                         log_q.size(), log_q[0].addr, rises[0], a);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] fa;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [31:0] e;
        logic [3:0]  s;
        int k1;
        int k2;
        txn_t st;
        for (int i = 0; i < 3; i++) begin
            fa = 32'h1000_0000 | ($urandom_range(0, 1023) << 2);
            ma = (i == 0) ? 32'h200 : 32'h2000_0000 | ($urandom_range(0, 255) << 2);
            wd = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            s  = (i == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
            k1 = (i == 0) ? 2 : $urandom_range(0, 4);
            k2 = (i == 0) ? 1 : $urandom_range(0, 4);
            e = mread(fa);
            st = '{we: 1'b1, sel: s, addr: ma, wdata: wd};
            lat_q.push_back(k1);
            lat_q.push_back(k2);
            log_q.delete();
            tick();
            if_ce = 1'b1;
            if_addr = fa;
            mem_ce = 1'b1;
            mem_we = 1'b1;
            mem_sel = s;
            mem_addr = ma;
            mem_wdata = wd;
            observe(60);
            mem_we = 1'b0;
            checks++;
            if (timed_out || mem_rel != k1 + 2 || mem_got !== 32'h0) begin
                errors++;
                $display("FAIL coll_store got rel=%0d res=%h want %0d 0",
                         mem_rel, mem_got, k1 + 2);
            end
            checks++;
            if (rises.size() != 2 || rises[0] != 1 || rises[1] != k1 + 3) begin
                errors++;
                $display("FAIL coll_gap got n=%0d r1=%0d want 2 %0d",
                         rises.size(), rises[1], k1 + 3);
            end
            checks++;
            if (if_rel != k1 + k2 + 4 || if_got !== e) begin
                errors++;
                $display("FAIL coll_fetch got rel=%0d data=%h want %0d %h",
                         if_rel, if_got, k1 + k2 + 4, e);
            end
            checks++;
            if (log_q.size() != 2 || log_q[0] !== st ||
                log_q[1].we !== 1'b0 || log_q[1].addr !== fa) begin
                errors++;
                $display("FAIL coll_order got n=%0d first=%h want 2 %h",
                         log_q.size(), log_q[0], st);
            end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] a;
        logic [31:0] old;
        logic [31:0] wd;
        logic [31:0] e;
        logic [3:0]  s;
        int k;
        for (int i = 0; i < 3; i++) begin
            a = 32'h3000_0000 | ($urandom_range(0, 255) << 2);
            old = mread(a);
            wd = $urandom;
            s = 4'($urandom_range(1, 15));
            e = old;
            for (int b = 0; b < 4; b++)
                if (s[b]) e[b*8 +: 8] = wd[b*8 +: 8];
            k = $urandom_range(0, 4);
            lat_q.push_back(k);
            tick();
            mem_ce = 1'b1;
            mem_we = 1'b1;
            mem_sel = s;
            mem_addr = a;
            mem_wdata = wd;
            observe(40);
            checks++;
            if (timed_out || mem_rel != k + 2 || mem_got !== 32'h0) begin
                errors++;
                $display("FAIL store got rel=%0d res=%h want %0d 0",
                         mem_rel, mem_got, k + 2);
            end
            k = $urandom_range(0, 4);
            lat_q.push_back(k);
            tick();
            mem_ce = 1'b1;
            mem_we = 1'b0;
            mem_sel = 4'hF;
            observe(40);
            checks++;
            if (timed_out || mem_rel != k + 2 || mem_got !== e) begin
                errors++;
                $display("FAIL load_back got rel=%0d data=%h want %0d %h",
                         mem_rel, mem_got, k + 2, e);
            end
        end
    endtask

    task automatic test_sticky_hold();
        logic [31:0] a;
        logic [31:0] e1;
        logic [31:0] e2;
        int k;
        int n;
        a = 32'h1000_0000 | ($urandom_range(0, 255) << 2);
        e1 = mread(a);
        e2 = mread(a + 32'd4);
        k = $urandom_range(0, 3);
        lat_q.push_back(k);
        lat_q.push_back(0);
        tick();
        hold_if = 1'b1;
        if_ce = 1'b1;
        if_addr = a;
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (stallreq_if && n < 40);
        checks++;
        if (n != k + 2 || if_data !== e1) begin
            errors++;
            $display("FAIL hold_first got n=%0d data=%h want %0d %h",
                     n, if_data, k + 2, e1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++;
            if (if_data !== e1 || stallreq_if !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable got data=%h sr=%b req=%b want %h 0 0",
                         if_data, stallreq_if, bus_req, e1);
            end
        end
        hold_if = 1'b0;
        if_addr = a + 32'd4;
        tick();
        #1;
        checks++;
        if (stallreq_if !== 1'b1) begin
            errors++;
            $display("FAIL hold_clear got %b want 1", stallreq_if);
        end
        n = 0;
        while (stallreq_if && n < 40) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (n != 2 || if_data !== e2) begin
            errors++;
            $display("FAIL hold_next got n=%0d data=%h want 2 %h", n, if_data, e2);
        end
        if_ce = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] fa;
        logic [31:0] ma;
        logic [31:0] ef;
        logic [31:0] em;
        for (int i = 0; i < 5; i++) begin
            fa = 32'h1000_0000 | ($urandom_range(0, 1023) << 2);
            ma = 32'h2000_0000 | ($urandom_range(0, 1023) << 2);
            ef = mread(fa);
            em = mread(ma);
            lat_q.push_back(0);
            lat_q.push_back(0);
            tick();
            if_ce = 1'b1;
            if_addr = fa;
            mem_ce = 1'b1;
            mem_we = 1'b0;
            mem_sel = 4'hF;
            mem_addr = ma;
            observe(30);
            checks++;
            if (timed_out || rises.size() != 2 || rises[0] != 1 || rises[1] != 3) begin
                errors++;
                $display("FAIL b2b_spacing got n=%0d r0=%0d r1=%0d want 2 1 3",
                         rises.size(), rises[0], rises[1]);
            end
            checks++;
            if (mem_rel != 2 || mem_got !== em || if_rel != 4 || if_got !== ef) begin
                errors++;
                $display("FAIL b2b_data got %0d %h %0d %h want 2 %h 4 %h",
                         mem_rel, mem_got, if_rel, if_got, em, ef);
            end
        end
        checks++;
        if (gap_viol != 0 || hold_viol != 0) begin
            errors++;
            $display("FAIL bus_protocol got gap=%0d hold=%0d want 0 0",
                     gap_viol, hold_viol);
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] a;
        logic [31:0] e;
        a = 32'h1000_0000 | ($urandom_range(0, 1023) << 2);
        resp_en = 1'b0;
        tick();
        if_ce = 1'b1;
        if_addr = a;
        observe(40);
        checks++;
        if (timed_out || if_rel != TO + 1 || if_got !== 32'h0) begin
            errors++;
            $display("FAIL timeout_abort got rel=%0d data=%h want %0d 0",
                     if_rel, if_got, TO + 1);
        end
        checks++;
        if (errs.size() != 1 || errs[0] != TO + 1) begin
            errors++;
            $display("FAIL timeout_err got n=%0d at=%0d want 1 %0d",
                     errs.size(), errs[0], TO + 1);
        end
        resp_en = 1'b1;
        e = mread(a);
        lat_q.push_back(TO - 1);
        tick();
        if_ce = 1'b1;
        observe(40);
        checks++;
        if (timed_out || if_rel != TO + 1 || if_got !== e || errs.size() != 0) begin
            errors++;
            $display("FAIL timeout_ack_wins got rel=%0d data=%h err=%0d want %0d %h 0",
                     if_rel, if_got, errs.size(), TO + 1, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_only();
        test_collision();
        test_load_store();
        test_sticky_hold();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (err_total != 0) begin
            errors++;
            $display("FAIL err_tied got %0d pulses want 0", err_total);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
